// File: rtl/hamming_pkg.sv
// Shared constants and types for the SECDED(16,11) serial link.
// Holds codeword geometry, the data-position table and the rx FSM states.
package hamming_pkg;

    localparam int CW_W      = 15;
    localparam int DATA_W    = 11;
    localparam int FRAME_LEN = 18;

    localparam int PAR_POS [4] = '{1, 2, 4, 8};

    localparam int DATA_POS [DATA_W] = '{
        3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_e;

endpackage

// File: rtl/hamming_secded_decode.sv
// Combinational SECDED(16,11) decoder.
// Ports: i_cw[15:1]=c15..c1, i_cw[0]=p0; o_data payload,
// o_corrected (single error fixed), o_uncorrectable (double error).
module hamming_secded_decode
    import hamming_pkg::*;
(
    input  logic [CW_W:0]     i_cw,
    output logic [DATA_W-1:0] o_data,
    output logic              o_corrected,
    output logic              o_uncorrectable
);

    logic [3:0]    w_syn;
    logic          w_par;
    logic [CW_W:0] w_fix;

    always_comb begin
        // Syndrome bit k covers every position whose index has PAR_POS[k] set,
        // which equals the XOR of the indices of all set bits.
        w_syn = '0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 1; i <= CW_W; i++) begin
                if ((i & PAR_POS[k]) != 0) begin
                    w_syn[k] = w_syn[k] ^ i_cw[i];
                end
            end
        end

        w_par = ^i_cw;

        // Only a parity-flagged error with nonzero syndrome is flipped; a
        // double error leaves the raw word so the raw data bits come out.
        w_fix = i_cw;
        if (w_par && (w_syn != 4'd0)) begin
            w_fix[w_syn] = ~i_cw[w_syn];
        end

        o_data = '0;
        for (int j = 0; j < DATA_W; j++) begin
            o_data[j] = w_fix[DATA_POS[j]];
        end

        o_corrected     = w_par;
        o_uncorrectable = !w_par && (w_syn != 4'd0);
    end

endmodule

// File: rtl/hamming_secded_serial_rx.sv
// Serial SECDED(16,11) receiver: start(1), c15..c1, p0, stop(0).
// Ports: bit_en/ser_in line sampling, clr_cnt; data_out + flags with
// out_valid pulse, busy, saturating corr_cnt/uncorr_cnt statistics.
module hamming_secded_serial_rx
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              ser_in,
    input  logic              clr_cnt,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              corrected,
    output logic              uncorrectable,
    output logic              frame_err,
    output logic              busy,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam int BCNT_W = $clog2(FRAME_LEN);

    state_e              r_state;
    state_e              w_next;
    logic [BCNT_W-1:0]   r_bitcnt;
    logic [CW_W:0]       r_shift;

    logic                w_start;
    logic                w_shift;
    logic                w_load;
    logic                w_busy;

    logic [DATA_W-1:0]   w_dec_data;
    logic                w_dec_corr;
    logic                w_dec_unc;

    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_corr;
    logic                r_unc;
    logic                r_ferr;
    logic [CNT_W-1:0]    r_corr_cnt;
    logic [CNT_W-1:0]    r_unc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (bit_en && ser_in) w_next = DATA;
            DATA: if (bit_en && (r_bitcnt == BCNT_W'(CW_W))) w_next = STOP;
            STOP: if (bit_en) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_start = bit_en && ser_in && (r_state == IDLE);
        w_shift = bit_en && (r_state == DATA);
        w_load  = bit_en && (r_state == STOP);
        w_busy  = (r_state != IDLE);
    end

    // MSB-first shifting leaves r_shift[i] = c_i and r_shift[0] = p0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
        end else if (w_start) begin
            r_bitcnt <= '0;
        end else if (w_shift) begin
            r_shift  <= {r_shift[CW_W-1:0], ser_in};
            r_bitcnt <= r_bitcnt + 1'b1;
        end
    end

    hamming_secded_decode u_dec (
        .i_cw            (r_shift),
        .o_data          (w_dec_data),
        .o_corrected     (w_dec_corr),
        .o_uncorrectable (w_dec_unc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_corr  <= 1'b0;
            r_unc   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= w_load;
            if (w_load) begin
                r_data <= w_dec_data;
                r_corr <= w_dec_corr;
                r_unc  <= w_dec_unc;
                r_ferr <= ser_in;
            end
        end
    end

    // Clear wins over a same-cycle increment; counts stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt <= '0;
            r_unc_cnt  <= '0;
        end else if (clr_cnt) begin
            r_corr_cnt <= '0;
            r_unc_cnt  <= '0;
        end else if (w_load) begin
            if (w_dec_corr && (r_corr_cnt != '1)) begin
                r_corr_cnt <= r_corr_cnt + 1'b1;
            end
            if (w_dec_unc && (r_unc_cnt != '1)) begin
                r_unc_cnt <= r_unc_cnt + 1'b1;
            end
        end
    end

    assign data_out      = r_data;
    assign out_valid     = r_valid;
    assign corrected     = r_corr;
    assign uncorrectable = r_unc;
    assign frame_err     = r_ferr;
    assign busy          = w_busy;
    assign corr_cnt      = r_corr_cnt;
    assign uncorr_cnt    = r_unc_cnt;

endmodule

// File: tb/tb_hamming_secded_serial_rx.sv
// Self-checking bench for hamming_secded_serial_rx.
// Directed vector table, reset/clear sequences, random frames vs a model.
module tb_hamming_secded_serial_rx;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = 255;
    localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_en = 1'b0;
    logic        ser_in = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [10:0] data_out;
    logic        out_valid;
    logic        corrected;
    logic        uncorrectable;
    logic        frame_err;
    logic        busy;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    int  ncmp = 0;
    int  nerr = 0;
    int  g_fno = 0;
    bit  g_at_edge = 1'b0;
    int  m_cc = 0;
    int  m_uc = 0;

    hamming_secded_serial_rx #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bit_en        (bit_en),
        .ser_in        (ser_in),
        .clr_cnt       (clr_cnt),
        .data_out      (data_out),
        .out_valid     (out_valid),
        .corrected     (corrected),
        .uncorrectable (uncorrectable),
        .frame_err     (frame_err),
        .busy          (busy),
        .corr_cnt      (corr_cnt),
        .uncorr_cnt    (uncorr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] pay;
        logic [15:0] flip;
        logic        stopb;
        int          gap;
        logic [10:0] edata;
        logic        ecorr;
        logic        eunc;
        int          ecc;
        int          euc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL frame%0d %s: got %0h want %0h",
                     g_fno, nm, act, exp);
        end
    endtask

    // Hamming encode from the position rules: data at DPOS, parity bit at
    // 2^k covers all positions whose index has bit k set, p0 even overall.
    function automatic logic [15:0] enc(input logic [10:0] d);
        logic [15:0] c;
        logic        p;
        c = '0;
        for (int i = 0; i < 11; i++) c[DPOS[i]] = d[i];
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int j = 1; j < 16; j++) begin
                if (((j >> k) & 1) == 1 && j != (1 << k)) p = p ^ c[j];
            end
            c[1 << k] = p;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] raw(input logic [15:0] c);
        logic [10:0] d;
        for (int i = 0; i < 11; i++) d[i] = c[DPOS[i]];
        return d;
    endfunction

    task automatic run_frame(input logic [15:0] cw, input logic stopb,
                             input int gap, input bit clr_stop,
                             input bit chain, input logic [10:0] ed,
                             input logic ec, input logic eu,
                             input int ecc, input int euc);
        logic [17:0] fr;
        bit          early;
        bit          busy_bad;
        fr = {1'b1, cw, stopb};
        early = 1'b0;
        busy_bad = 1'b0;
        g_fno++;
        for (int k = 17; k >= 0; k--) begin
            for (int g = 0; g < gap; g++) begin
                if (!g_at_edge) @(negedge clk);
                g_at_edge = 1'b0;
                if (k < 17 && !busy) busy_bad = 1'b1;
                if (k < 17 && out_valid) early = 1'b1;
                bit_en = 1'b0;
                clr_cnt = 1'b0;
            end
            if (!g_at_edge) @(negedge clk);
            g_at_edge = 1'b0;
            if (k < 17 && !busy) busy_bad = 1'b1;
            if (k < 17 && out_valid) early = 1'b1;
            bit_en = 1'b1;
            ser_in = fr[k];
            clr_cnt = (k == 0) && clr_stop;
        end
        @(negedge clk);
        bit_en = 1'b0;
        ser_in = 1'b0;
        clr_cnt = 1'b0;
        chk("early_valid", 32'(early), 32'd0);
        chk("busy_in_frame", 32'(busy_bad), 32'd0);
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("data_out", 32'(data_out), 32'(ed));
        chk("corrected", 32'(corrected), 32'(ec));
        chk("uncorrectable", 32'(uncorrectable), 32'(eu));
        chk("frame_err", 32'(frame_err), 32'(stopb));
        chk("corr_cnt", 32'(corr_cnt), 32'(ecc));
        chk("uncorr_cnt", 32'(uncorr_cnt), 32'(euc));
        if (chain) begin
            g_at_edge = 1'b1;
        end else begin
            @(negedge clk);
            chk("pulse_width", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(data_out), 32'd0);
        chk({tag, "_corr"}, 32'(corrected), 32'd0);
        chk({tag, "_unc"}, 32'(uncorrectable), 32'd0);
        chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ccnt"}, 32'(corr_cnt), 32'd0);
        chk({tag, "_ucnt"}, 32'(uncorr_cnt), 32'd0);
    endtask

    // Model: the number of injected errors alone decides the outcome.
    task automatic rand_frame(input int nerr_in, input bit chain,
                              input bit clr_stop);
        logic [10:0] pay;
        logic [15:0] cw;
        int          e1;
        int          e2;
        logic [10:0] ed;
        pay = 11'($urandom);
        cw = enc(pay);
        e1 = $urandom_range(0, 15);
        e2 = (e1 + $urandom_range(1, 15)) % 16;
        if (nerr_in >= 1) cw[e1] = ~cw[e1];
        if (nerr_in == 2) cw[e2] = ~cw[e2];
        ed = (nerr_in == 2) ? raw(cw) : pay;
        if (clr_stop) begin
            m_cc = 0;
            m_uc = 0;
        end else begin
            if (nerr_in == 1 && m_cc < CNT_MAX) m_cc++;
            if (nerr_in == 2 && m_uc < CNT_MAX) m_uc++;
        end
        run_frame(cw, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                  clr_stop, chain, ed, nerr_in == 1, nerr_in == 2,
                  m_cc, m_uc);
    endtask

    vec_t tv [6];

    initial begin
        tv[0] = '{11'h7FF, 16'h0000, 1'b0, 0, 11'h7FF, 1'b0, 1'b0, 0, 0};
        tv[1] = '{11'h7FF, 16'h0020, 1'b0, 0, 11'h7FF, 1'b1, 1'b0, 1, 0};
        tv[2] = '{11'h7FF, 16'h0001, 1'b0, 0, 11'h7FF, 1'b1, 1'b0, 2, 0};
        tv[3] = '{11'h000, 16'h0028, 1'b0, 0, 11'h003, 1'b0, 1'b1, 2, 1};
        tv[4] = '{11'h000, 16'h0000, 1'b1, 0, 11'h000, 1'b0, 1'b0, 2, 1};
        tv[5] = '{11'h000, 16'h0000, 1'b0, 2, 11'h000, 1'b0, 1'b0, 2, 1};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_frame(enc(tv[i].pay) ^ tv[i].flip, tv[i].stopb, tv[i].gap,
                      1'b0, 1'b0, tv[i].edata, tv[i].ecorr, tv[i].eunc,
                      tv[i].ecc, tv[i].euc);
        end

        begin
            logic [17:0] fr;
            bit          seen;
            fr = {1'b1, enc(11'h5A5), 1'b0};
            for (int k = 17; k >= 10; k--) begin
                @(negedge clk);
                bit_en = 1'b1;
                ser_in = fr[k];
            end
            @(negedge clk);
            chk("busy_mid", 32'(busy), 32'd1);
            bit_en = 1'b0;
            ser_in = 1'b0;
            rst_n = 1'b0;
            #1;
            check_zero("midrst");
            @(negedge clk);
            rst_n = 1'b1;
            seen = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            chk("midrst_no_valid", 32'(seen), 32'd0);
        end
        m_cc = 0;
        m_uc = 0;

        run_frame(enc(11'h7FF), 1'b0, 0, 1'b0, 1'b0, 11'h7FF,
                  1'b0, 1'b0, 0, 0);
        run_frame(enc(11'h123) ^ 16'h0200, 1'b0, 1, 1'b0, 1'b0, 11'h123,
                  1'b1, 1'b0, 1, 0);
        run_frame(enc(11'h123) ^ 16'h8004, 1'b0, 0, 1'b0, 1'b0,
                  raw(enc(11'h123) ^ 16'h8004), 1'b0, 1'b1, 1, 1);
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        chk("clr_ccnt", 32'(corr_cnt), 32'd0);
        chk("clr_ucnt", 32'(uncorr_cnt), 32'd0);
        chk("held_unc", 32'(uncorrectable), 32'd1);

        for (int n = 0; n < 60; n++) begin
            rand_frame($urandom_range(0, 2), (n != 59) && $urandom_range(0, 1) == 1, 1'b0);
        end

        for (int n = 0; n < 256; n++) begin
            rand_frame(1, n != 255, 1'b0);
        end
        chk("sat_ccnt", 32'(corr_cnt), 32'(CNT_MAX));

        rand_frame(1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
